// File: rtl/coretech_pkg.sv
// Shared CoreTech definitions: sequencer state encoding, opcode values and ALU operation codes.
package coretech_pkg;

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_FETCH     = 3'd1,
      S_DECODE    = 3'd2,
      S_EXECUTE   = 3'd3,
      S_MEM       = 3'd4,
      S_WRITEBACK = 3'd5,
      S_HALTED    = 3'd6,
      S_FAULT     = 3'd7
   } seq_state_t;

   localparam logic [7:0] OP_MOV_IMM = 8'h00;
   localparam logic [7:0] OP_MOV_REG = 8'h01;
   localparam logic [7:0] OP_LOAD    = 8'h02;
   localparam logic [7:0] OP_STORE   = 8'h03;
   localparam logic [7:0] OP_JMP     = 8'h05;
   localparam logic [7:0] OP_ADD     = 8'h09;
   localparam logic [7:0] OP_SUB     = 8'h0A;
   localparam logic [7:0] OP_AND     = 8'h0B;
   localparam logic [7:0] OP_OR      = 8'h0C;
   localparam logic [7:0] OP_HALT    = 8'hFF;

   typedef enum logic [2:0] {
      ALU_ADD    = 3'd0,
      ALU_SUB    = 3'd1,
      ALU_AND    = 3'd2,
      ALU_OR     = 3'd3,
      ALU_PASS_A = 3'd4,
      ALU_PASS_B = 3'd5
   } alu_op_t;

endpackage

// File: rtl/mem_wait_timer.sv
// Counts memory wait cycles; expired flags that TIMEOUT waits have elapsed (never when TIMEOUT is 0).
module mem_wait_timer #(
   parameter int unsigned TIMEOUT = 255,
   parameter int unsigned TMR_W   = 8
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic count_en,
   output logic expired
);

   logic [TMR_W-1:0] count;

   assign expired = (TIMEOUT != 0) && (count == TMR_W'(TIMEOUT));

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         count <= '0;
      end else if (count_en && !expired) begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/multicycle_sequencer.sv
// Multi-cycle control sequencer: walks fetch/decode/execute/mem/writeback and gates decoder
// controls into single-cycle write strobes, with halt, memory-timeout fault and retire count.
module multicycle_sequencer
   import coretech_pkg::*;
#(
   parameter int unsigned CNT_W   = 16,
   parameter int unsigned TIMEOUT = 255,
   parameter int unsigned TMR_W   = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             run,
   input  logic             imem_ready,
   input  logic             dmem_ready,
   input  logic             jump,
   input  logic             mem_read,
   input  logic             mem_write,
   input  logic             reg_write,
   input  logic             halt,
   output logic             imem_req,
   output logic             ir_we,
   output logic             alu_we,
   output logic             dmem_re,
   output logic             dmem_we,
   output logic             rf_we,
   output logic             pc_we,
   output logic             pc_sel,
   output logic             halted,
   output logic             fault,
   output logic [2:0]       state,
   output logic [CNT_W-1:0] retired_count
);

   seq_state_t state_q;
   logic       jump_q, mem_read_q, mem_write_q, reg_write_q;
   logic       halted_q, fault_q;
   logic       tmr_clear, tmr_count_en, tmr_expired;

   // Holding the counter clear outside FETCH/MEM guarantees it starts at zero on every entry.
   assign tmr_clear    = !(state_q == S_FETCH || state_q == S_MEM);
   assign tmr_count_en = (state_q == S_FETCH && !imem_ready) ||
                         (state_q == S_MEM   && !dmem_ready);

   mem_wait_timer #(
      .TIMEOUT(TIMEOUT),
      .TMR_W  (TMR_W)
   ) u_timer (
      .clk     (clk),
      .rst     (rst),
      .clear   (tmr_clear),
      .count_en(tmr_count_en),
      .expired (tmr_expired)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= S_IDLE;
         jump_q        <= 1'b0;
         mem_read_q    <= 1'b0;
         mem_write_q   <= 1'b0;
         reg_write_q   <= 1'b0;
         halted_q      <= 1'b0;
         fault_q       <= 1'b0;
         retired_count <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (run) state_q <= S_FETCH;
            end
            S_FETCH: begin
               if (imem_ready) begin
                  state_q <= S_DECODE;
               end else if (tmr_expired) begin
                  state_q <= S_FAULT;
                  fault_q <= 1'b1;
               end
            end
            S_DECODE: begin
               jump_q      <= jump;
               mem_read_q  <= mem_read;
               mem_write_q <= mem_write;
               reg_write_q <= reg_write;
               if (halt) begin
                  state_q  <= S_HALTED;
                  halted_q <= 1'b1;
               end else begin
                  state_q <= S_EXECUTE;
               end
            end
            S_EXECUTE: begin
               state_q <= (mem_read_q || mem_write_q) ? S_MEM : S_WRITEBACK;
            end
            S_MEM: begin
               if (dmem_ready) begin
                  state_q <= S_WRITEBACK;
               end else if (tmr_expired) begin
                  state_q <= S_FAULT;
                  fault_q <= 1'b1;
               end
            end
            S_WRITEBACK: begin
               if (retired_count != '1) retired_count <= retired_count + 1'b1;
               state_q <= run ? S_FETCH : S_IDLE;
            end
            S_HALTED, S_FAULT: begin
               state_q <= state_q;
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   always_comb begin
      imem_req = 1'b0;
      ir_we    = 1'b0;
      alu_we   = 1'b0;
      dmem_re  = 1'b0;
      dmem_we  = 1'b0;
      rf_we    = 1'b0;
      pc_we    = 1'b0;
      pc_sel   = 1'b0;
      case (state_q)
         S_FETCH: begin
            imem_req = 1'b1;
            ir_we    = imem_ready;
         end
         S_EXECUTE: begin
            alu_we = 1'b1;
         end
         S_MEM: begin
            dmem_we = mem_write_q;
            dmem_re = mem_read_q && !mem_write_q;
         end
         S_WRITEBACK: begin
            rf_we  = reg_write_q;
            pc_we  = 1'b1;
            pc_sel = jump_q;
         end
         default: begin
            imem_req = 1'b0;
         end
      endcase
   end

   assign halted = halted_q;
   assign fault  = fault_q;
   assign state  = state_q;

endmodule
